// File: rtl/filter_luma_8tap_if.sv
// Tagged multi-flux FIFO port bundles shared by the luma filter actors.
// read_interface: per-flux show-ahead head words; write_interface: single output FIFO.
interface read_interface #(
  parameter int FLUX  = 2,
  parameter int WIDTH = 10
);
  logic [FLUX-1:0]            empty;
  logic [FLUX-1:0]            read;
  logic [FLUX-1:0][WIDTH-1:0] dout;

  modport actor  (input empty, input dout, output read);
  modport fifo   (output empty, output dout, input read);
  modport slave  (input empty, input dout, output read);
  modport master (output empty, output dout, input read);
endinterface

interface write_interface #(
  parameter int WIDTH = 17
);
  logic             full;
  logic [WIDTH-1:0] din;
  logic             write;

  modport actor  (input full, output din, output write);
  modport fifo   (output full, input din, input write);
  modport slave  (input full, output din, output write);
  modport master (output full, input din, input write);
endinterface

// File: rtl/filter_luma_8tap.sv
// HEVC luma 8-tap serial MAC: one coefficient set + eight samples in, one result out.
// Define FILTER_LUMA_8TAP_CLIP_EN for final-pixel rounding/clipping instead of raw acc.
module filter_luma_8tap #(
  parameter int FLUX         = 2,
  parameter int TAG_WIDTH    = $clog2(FLUX),
  parameter int COEF_WIDTH   = 9,
  parameter int SAMPLE_WIDTH = 8,
  parameter int OUT_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  read_interface.actor  read_port_c0,
  read_interface.actor  read_port_c1,
  read_interface.actor  read_port_c2,
  read_interface.actor  read_port_c3,
  read_interface.actor  read_port_c4,
  read_interface.actor  read_port_c5,
  read_interface.actor  read_port_c6,
  read_interface.actor  read_port_c7,
  read_interface.actor  read_port_sample,
  write_interface.actor write_port_dst
);
  localparam int ACC_W  = 20;
  localparam int PROD_W = COEF_WIDTH + SAMPLE_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                      r_state, w_state_nxt;
  logic signed [ACC_W-1:0]     r_acc;
  logic [2:0]                  r_cnt;
  logic [TAG_WIDTH-1:0]        r_tag;
  logic [7:0][COEF_WIDTH-1:0]  r_coef;

  logic [7:0][FLUX-1:0]        w_c_empty;
  logic [7:0][COEF_WIDTH-1:0]  w_c_data;
  logic [FLUX-1:0]             w_elig, w_c_rd, w_s_rd;
  logic                        w_any, w_s_take, w_wr;
  logic [TAG_WIDTH-1:0]        w_sel;
  logic [SAMPLE_WIDTH-1:0]     w_smp;
  logic signed [PROD_W-1:0]    w_prod;
  logic [OUT_WIDTH-1:0]        w_result;

  assign w_c_empty[0] = read_port_c0.empty;
  assign w_c_empty[1] = read_port_c1.empty;
  assign w_c_empty[2] = read_port_c2.empty;
  assign w_c_empty[3] = read_port_c3.empty;
  assign w_c_empty[4] = read_port_c4.empty;
  assign w_c_empty[5] = read_port_c5.empty;
  assign w_c_empty[6] = read_port_c6.empty;
  assign w_c_empty[7] = read_port_c7.empty;

  // Coefficient data of the flux chosen this cycle (tag bits are not checked)
  assign w_c_data[0] = read_port_c0.dout[w_sel][COEF_WIDTH-1:0];
  assign w_c_data[1] = read_port_c1.dout[w_sel][COEF_WIDTH-1:0];
  assign w_c_data[2] = read_port_c2.dout[w_sel][COEF_WIDTH-1:0];
  assign w_c_data[3] = read_port_c3.dout[w_sel][COEF_WIDTH-1:0];
  assign w_c_data[4] = read_port_c4.dout[w_sel][COEF_WIDTH-1:0];
  assign w_c_data[5] = read_port_c5.dout[w_sel][COEF_WIDTH-1:0];
  assign w_c_data[6] = read_port_c6.dout[w_sel][COEF_WIDTH-1:0];
  assign w_c_data[7] = read_port_c7.dout[w_sel][COEF_WIDTH-1:0];

  assign read_port_c0.read = w_c_rd;
  assign read_port_c1.read = w_c_rd;
  assign read_port_c2.read = w_c_rd;
  assign read_port_c3.read = w_c_rd;
  assign read_port_c4.read = w_c_rd;
  assign read_port_c5.read = w_c_rd;
  assign read_port_c6.read = w_c_rd;
  assign read_port_c7.read = w_c_rd;
  assign read_port_sample.read = w_s_rd;

  // A flux is eligible only when all eight taps are present; highest index wins
  always_comb begin
    w_elig = '1;
    w_sel  = '0;
    for (int k = 0; k < 8; k++) w_elig = w_elig & ~w_c_empty[k];
    for (int f = 0; f < FLUX; f++)
      if (w_elig[f]) w_sel = TAG_WIDTH'(f);
  end
  assign w_any = |w_elig;

  assign w_smp    = read_port_sample.dout[r_tag][SAMPLE_WIDTH-1:0];
  assign w_s_take = (r_state == MAC) && !read_port_sample.empty[r_tag];
  assign w_prod   = $signed(r_coef[r_cnt]) * $signed({1'b0, w_smp});

  // Strobes are forced low while reset_n is asserted
  always_comb begin
    w_state_nxt = r_state;
    w_c_rd      = '0;
    w_s_rd      = '0;
    w_wr        = 1'b0;
    if (reset_n) begin
      case (r_state)
        IDLE: if (w_any) begin
          w_c_rd[w_sel] = 1'b1;
          w_state_nxt   = MAC;
        end
        MAC: if (w_s_take) begin
          w_s_rd[r_tag] = 1'b1;
          if (r_cnt == 3'd7) w_state_nxt = OUT;
        end
        OUT: if (!write_port_dst.full) begin
          w_wr        = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_tag   <= '0;
      r_coef  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        r_coef <= w_c_data;
        r_tag  <= w_sel;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (w_s_take) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

`ifdef FILTER_LUMA_8TAP_CLIP_EN
  logic signed [ACC_W-1:0] w_rnd;
  assign w_rnd = (r_acc + ACC_W'(32)) >>> 6;

  always_comb begin
    w_result = '0;
    if (w_rnd[ACC_W-1])
      w_result = '0;
    else if (w_rnd > ACC_W'((1 << SAMPLE_WIDTH) - 1))
      w_result = OUT_WIDTH'((1 << SAMPLE_WIDTH) - 1);
    else
      w_result = OUT_WIDTH'(w_rnd[SAMPLE_WIDTH-1:0]);
  end
`else
  assign w_result = r_acc[OUT_WIDTH-1:0];
`endif

  assign write_port_dst.write = w_wr;
  assign write_port_dst.din   = {r_tag, w_result};

endmodule

// File: tb/tb_filter_luma_8tap.sv
// Scoreboard bench for filter_luma_8tap: behavioural tagged FIFOs around the DUT,
// expected results queued at stimulus time and popped by an output monitor.
module tb_filter_luma_8tap;
  localparam int FLUX = 2, TW = 1, CW = 9, SW = 8, OW = 16;
  localparam int CWD = TW + CW, SWD = TW + SW, OWD = TW + OW;

  localparam int C1[8] = '{0, 0, 0, 64, 0, 0, 0, 0};
  localparam int S1[8] = '{10, 11, 12, 13, 14, 15, 16, 17};
  localparam int C2[8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  localparam int S2[8] = '{100, 100, 100, 100, 100, 100, 100, 100};
  localparam int C3[8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  localparam int S3[8] = '{255, 0, 255, 0, 0, 0, 0, 0};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  read_interface  #(.FLUX(FLUX), .WIDTH(CWD)) cif [8] ();
  read_interface  #(.FLUX(FLUX), .WIDTH(SWD)) sif ();
  write_interface #(.WIDTH(OWD))              dif ();

  logic [7:0][FLUX-1:0]           c_empty, c_rd, c_rd_cap;
  logic [7:0][FLUX-1:0][CWD-1:0]  c_dout;
  logic [FLUX-1:0]                s_empty, s_rd, s_rd_cap, s_rd_seen;
  logic [FLUX-1:0][SWD-1:0]       s_dout;
  logic                           full, smp_block;

  logic [CWD-1:0] cq [8][FLUX][$];
  logic [SWD-1:0] sq [FLUX][$];
  logic [OWD-1:0] exp_q [$];
  int n_chk = 0, n_pass = 0;

  for (genvar k = 0; k < 8; k++) begin : g_c
    assign cif[k].empty = c_empty[k];
    assign cif[k].dout  = c_dout[k];
    assign c_rd[k]      = cif[k].read;
  end
  assign sif.empty = s_empty;
  assign sif.dout  = s_dout;
  assign s_rd      = sif.read;
  assign dif.full  = full;

  filter_luma_8tap dut (
    .clk(clk), .reset_n(reset_n),
    .read_port_c0(cif[0]), .read_port_c1(cif[1]), .read_port_c2(cif[2]), .read_port_c3(cif[3]),
    .read_port_c4(cif[4]), .read_port_c5(cif[5]), .read_port_c6(cif[6]), .read_port_c7(cif[7]),
    .read_port_sample(sif), .write_port_dst(dif)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, want);
  endtask

  task automatic refresh();
    for (int k = 0; k < 8; k++)
      for (int f = 0; f < FLUX; f++) begin
        c_empty[k][f] = (cq[k][f].size() == 0);
        c_dout[k][f]  = (cq[k][f].size() != 0) ? cq[k][f][0] : '0;
      end
    for (int f = 0; f < FLUX; f++) begin
      s_empty[f] = smp_block || (sq[f].size() == 0);
      s_dout[f]  = (sq[f].size() != 0) ? sq[f][0] : '0;
    end
  endtask

  // One clock: strobes seen before the edge pop the model FIFOs just after it
  task automatic tick();
    logic [CWD-1:0] dc;
    logic [SWD-1:0] ds;
    @(negedge clk);
    c_rd_cap = c_rd;
    s_rd_cap = s_rd;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++)
      for (int f = 0; f < FLUX; f++)
        if (c_rd_cap[k][f]) begin
          if (cq[k][f].size() != 0) dc = cq[k][f].pop_front();
          else begin n_chk++; $display("FAIL coef_read_on_empty: port %0d flux %0d", k, f); end
        end
    for (int f = 0; f < FLUX; f++)
      if (s_rd_cap[f]) begin
        if (sq[f].size() != 0) ds = sq[f].pop_front();
        else begin n_chk++; $display("FAIL sample_read_on_empty: flux %0d", f); end
      end
    s_rd_seen = s_rd_seen | s_rd_cap;
    refresh();
    #1;
  endtask

  task automatic push_tok(input int f, input int c[8], input int s[8], input logic [15:0] raw,
                          input logic [7:0] clp, input bit want, output logic [OWD-1:0] ev);
    int cv, sv;
    logic [TW-1:0] t;
    cv = f;
    t  = cv[TW-1:0];
    for (int k = 0; k < 8; k++) begin
      cv = c[k];
      sv = s[k];
      cq[k][f].push_back({t, cv[CW-1:0]});
      sq[f].push_back({t, sv[SW-1:0]});
    end
`ifdef FILTER_LUMA_8TAP_CLIP_EN
    ev = {t, 8'h00, clp};
`else
    ev = {t, raw};
`endif
    if (want) exp_q.push_back(ev);
    refresh();
    #1;
  endtask

  task automatic run_to_write(output int n);
    n = 1;
    while (!dif.write && n < 60) begin
      tick();
      n++;
    end
  endtask

  always @(negedge clk) begin
    logic [OWD-1:0] e;
    if (reset_n && dif.write) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: din %0h with empty scoreboard", dif.din);
      end else begin
        e = exp_q.pop_front();
        chk("dst_din", 32'(dif.din), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OWD-1:0] ev;
    int n, cnt;
    full = 1'b0; smp_block = 1'b0; s_rd_seen = '0; reset_n = 1'b0;
    refresh();

    // Token queued while in reset: strobes must stay low
    push_tok(0, C1, S1, 16'd832, 8'd13, 1'b1, ev);
    tick(); tick();
    chk("rst_write", 32'(dif.write), 0);
    chk("rst_coef_rd", 32'(c_rd), 0);
    chk("rst_smp_rd", 32'(s_rd), 0);
    reset_n = 1'b1;
    #1;
    chk("t1_coef_rd", 32'(c_rd[0]), 32'b01);
    run_to_write(n);
    chk("t1_latency", n, 10);
    tick();

    push_tok(1, C2, S2, 16'd6400, 8'd100, 1'b1, ev);
    run_to_write(n);
    chk("t2_latency", n, 10);
    tick();

    push_tok(0, C3, S3, 16'hF50B, 8'd0, 1'b1, ev);
    run_to_write(n);
    chk("t3_latency", n, 10);
    tick();

    // 3-cycle sample stall after the 4th sample, then 5 cycles of full in OUT
    full = 1'b1;
    push_tok(0, C1, S1, 16'd832, 8'd13, 1'b1, ev);
    repeat (5) tick();
    smp_block = 1'b1; refresh(); #1;
    repeat (3) begin
      chk("t4_stall_srd", 32'(s_rd), 0);
      tick();
    end
    smp_block = 1'b0; refresh(); #1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_full_write", 32'(dif.write), 0);
      chk("t4_full_din", 32'(dif.din), 32'(ev));
      tick();
    end
    full = 1'b0;
    #1;
    chk("t4_write_on_release", 32'(dif.write), 1);
    tick();

    // Both fluxes ready together: flux 1 first, flux 0 untouched meanwhile
    s_rd_seen = '0;
    push_tok(1, C2, S2, 16'd6400, 8'd100, 1'b1, ev);
    push_tok(0, C3, S3, 16'hF50B, 8'd0, 1'b1, ev);
    chk("t5_coef_rd_hi", 32'(c_rd[3]), 32'b10);
    run_to_write(n);
    chk("t5_latency_f1", n, 10);
    chk("t5_smp_rd_only_f1", 32'(s_rd_seen), 32'b10);
    cnt = 0;
    for (int k = 0; k < 8; k++) cnt += cq[k][0].size();
    chk("t5_f0_untouched", cnt, 8);
    tick();
    chk("t5_f0_start", 32'(c_rd[0]), 32'b01);
    run_to_write(n);
    chk("t5_latency_f0", n, 10);
    tick();

    // Reset at cnt==5 discards the token
    push_tok(1, C2, S2, 16'd6400, 8'd100, 1'b0, ev);
    repeat (6) tick();
    chk("t6_mid_mac_srd", 32'(s_rd), 32'b10);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_srd", 32'(s_rd), 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("t6_idle_srd", 32'(s_rd), 0);
    chk("t6_idle_crd", 32'(c_rd), 0);
    chk("t6_idle_write", 32'(dif.write), 0);
    sq[1].delete();
    refresh();
    push_tok(0, C1, S1, 16'd832, 8'd13, 1'b1, ev);
    run_to_write(n);
    chk("t6_latency", n, 10);
    tick();
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
